// File: rtl/bincnt_accum.sv
`default_nettype none
// ============================================================================
// Module      : bincnt_accum
// Description : Frame popcount accumulator built on a 7-input bit counter.
//               Macro BINCNT_ACCUM_SAT_EN selects saturating accumulators.
// Revision    : 1.0 - initial release
// ============================================================================

module counter7b3 (
    input  logic [6:0] in_bits,
    output logic [2:0] count
);
    logic w_s0, w_c0, w_s1, w_c1, w_c2;

    // Full-adder tree: three weight-1 sums, then the weight-2 carries added.
    assign w_s0 = in_bits[0] ^ in_bits[1] ^ in_bits[2];
    assign w_c0 = (in_bits[0] & in_bits[1]) | (in_bits[2] & (in_bits[0] ^ in_bits[1]));
    assign w_s1 = in_bits[3] ^ in_bits[4] ^ in_bits[5];
    assign w_c1 = (in_bits[3] & in_bits[4]) | (in_bits[5] & (in_bits[3] ^ in_bits[4]));
    assign w_c2 = (w_s0 & w_s1) | (in_bits[6] & (w_s0 ^ w_s1));

    assign count[0] = w_s0 ^ w_s1 ^ in_bits[6];
    assign count[1] = w_c0 ^ w_c1 ^ w_c2;
    assign count[2] = (w_c0 & w_c1) | (w_c2 & (w_c0 ^ w_c1));
endmodule

module bincnt_accum #(
    parameter int ACC_W  = 16,
    parameter int BEAT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_count,
    output logic [BEAT_W-1:0] out_beats,
    output logic              out_ovf
);
    localparam logic [0:0] c_ST_ACC  = 1'b0;
    localparam logic [0:0] c_ST_HOLD = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic [ACC_W-1:0]  r_acc;
    logic [BEAT_W-1:0] r_beats;
    logic              r_ovf;
    logic              r_in_ready;

    logic [2:0]        w_cnt7;
    logic              w_accept;
    logic [ACC_W:0]    w_acc_sum;
    logic [BEAT_W:0]   w_beats_sum;
    logic [ACC_W-1:0]  w_acc_next;
    logic [BEAT_W-1:0] w_beats_next;
    logic              w_ovf_next;

    counter7b3 u_counter7b3 (
        .in_bits (in_data),
        .count   (w_cnt7)
    );

    assign w_accept    = in_valid && r_in_ready;
    assign w_acc_sum   = {1'b0, r_acc} + (ACC_W+1)'(w_cnt7);
    assign w_beats_sum = {1'b0, r_beats} + (BEAT_W+1)'(1);
    assign w_ovf_next  = r_ovf | w_acc_sum[ACC_W] | w_beats_sum[BEAT_W];

    always_comb begin
`ifdef BINCNT_ACCUM_SAT_EN
        w_acc_next   = w_acc_sum[ACC_W]     ? {ACC_W{1'b1}}  : w_acc_sum[ACC_W-1:0];
        w_beats_next = w_beats_sum[BEAT_W]  ? {BEAT_W{1'b1}} : w_beats_sum[BEAT_W-1:0];
`else
        w_acc_next   = w_acc_sum[ACC_W-1:0];
        w_beats_next = w_beats_sum[BEAT_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clr) begin
            w_state_next = c_ST_ACC;
        end else begin
            case (r_state)
                c_ST_ACC:  if (w_accept && in_last) w_state_next = c_ST_HOLD;
                c_ST_HOLD: if (out_ready)           w_state_next = c_ST_ACC;
                default:                            w_state_next = c_ST_ACC;
            endcase
        end
    end

    always_comb begin
        out_valid = (r_state == c_ST_HOLD);
    end

    assign in_ready = r_in_ready;

    // in_ready is a registered decode of the next state, so it never sees out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
            r_acc      <= '0;
            r_beats    <= '0;
            r_ovf      <= 1'b0;
            out_count  <= '0;
            out_beats  <= '0;
            out_ovf    <= 1'b0;
        end else begin
            r_in_ready <= (w_state_next == c_ST_ACC);
            if (clr) begin
                r_acc   <= '0;
                r_beats <= '0;
                r_ovf   <= 1'b0;
            end else if (w_accept) begin
                if (in_last) begin
                    out_count <= w_acc_next;
                    out_beats <= w_beats_next;
                    out_ovf   <= w_ovf_next;
                    r_acc     <= '0;
                    r_beats   <= '0;
                    r_ovf     <= 1'b0;
                end else begin
                    r_acc     <= w_acc_next;
                    r_beats   <= w_beats_next;
                    r_ovf     <= w_ovf_next;
                end
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_bincnt_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_bincnt_accum
// Description : Directed bench for bincnt_accum at default and narrow widths.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_bincnt_accum;
    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic [6:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic        rdy0, vld0, ovf0;
    logic [15:0] cnt0;
    logic [7:0]  bts0;
    logic        rdy4, vld4, ovf4;
    logic [3:0]  cnt4;
    logic [7:0]  bts4;
    logic        rdy2, vld2, ovf2;
    logic [15:0] cnt2;
    logic [1:0]  bts2;

    int n_tests = 0;
    int n_fail  = 0;

    bincnt_accum u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_last(in_last), .out_valid(vld0), .out_ready(out_ready),
        .out_count(cnt0), .out_beats(bts0), .out_ovf(ovf0)
    );

    bincnt_accum #(.ACC_W(4), .BEAT_W(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy4),
        .in_data(in_data), .in_last(in_last), .out_valid(vld4), .out_ready(out_ready),
        .out_count(cnt4), .out_beats(bts4), .out_ovf(ovf4)
    );

    bincnt_accum #(.ACC_W(16), .BEAT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy2),
        .in_data(in_data), .in_last(in_last), .out_valid(vld2), .out_ready(out_ready),
        .out_count(cnt2), .out_beats(bts2), .out_ovf(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one beat for a single edge; returns 1 time unit after that edge.
    task automatic drive_beat(input logic [6:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 7'h00;
        in_last  = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 7'h00; in_last = 1'b0; out_ready = 1'b0;
        #12;
        n_tests++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", rdy0); end
        n_tests++; if (vld0 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", vld0); end
        n_tests++; if (cnt0 !== 16'd0) begin n_fail++; $display("FAIL reset_out_count: got %0d expected 0", cnt0); end
        n_tests++; if (bts0 !== 8'd0) begin n_fail++; $display("FAIL reset_out_beats: got %0d expected 0", bts0); end
        n_tests++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %b expected 0", ovf0); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL release_ready_before_edge: got %b expected 0", rdy0); end
        @(posedge clk);
        #1;
        n_tests++; if ({rdy0, rdy4, rdy2} !== 3'b111) begin n_fail++; $display("FAIL release_ready_after_edge: got %b expected 111", {rdy0, rdy4, rdy2}); end
    endtask

    task automatic test_basic_frame();
        drive_beat(7'h7F, 1'b0);
        n_tests++; if (vld0 !== 1'b0) begin n_fail++; $display("FAIL basic_mid_valid: got %b expected 0", vld0); end
        n_tests++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL basic_mid_ready: got %b expected 1", rdy0); end
        drive_beat(7'h01, 1'b0);
        drive_beat(7'h55, 1'b1);
        n_tests++; if (vld0 !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", vld0); end
        n_tests++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL basic_ready_low: got %b expected 0", rdy0); end
        n_tests++; if (cnt0 !== 16'd12) begin n_fail++; $display("FAIL basic_count: got %0d expected 12", cnt0); end
        n_tests++; if (bts0 !== 8'd3) begin n_fail++; $display("FAIL basic_beats: got %0d expected 3", bts0); end
        n_tests++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b expected 0", ovf0); end
        release_result();
        n_tests++; if ({vld0, rdy0} !== 2'b01) begin n_fail++; $display("FAIL basic_release: got valid,ready=%b expected 01", {vld0, rdy0}); end
    endtask

    task automatic test_hold_backpressure();
        drive_beat(7'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (vld0 !== 1'b1 || rdy0 !== 1'b0 || cnt0 !== 16'd0 || bts0 !== 8'd1)
            begin n_fail++; $display("FAIL hold_cycle%0d: got valid=%b ready=%b count=%0d beats=%0d expected 1 0 0 1", i, vld0, rdy0, cnt0, bts0); end
            @(posedge clk);
            #1;
        end
        release_result();
        n_tests++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL hold_ready_return: got %b expected 1", rdy0); end
        drive_beat(7'h7F, 1'b1);
        n_tests++; if (vld0 !== 1'b1 || cnt0 !== 16'd7 || bts0 !== 8'd1)
        begin n_fail++; $display("FAIL back_to_back: got valid=%b count=%0d beats=%0d expected 1 7 1", vld0, cnt0, bts0); end
        release_result();
    endtask

    task automatic test_acc_overflow();
        logic [3:0] exp_cnt4;
`ifdef BINCNT_ACCUM_SAT_EN
        exp_cnt4 = 4'd15;
`else
        exp_cnt4 = 4'd5;
`endif
        drive_beat(7'h7F, 1'b0);
        drive_beat(7'h7F, 1'b0);
        drive_beat(7'h7F, 1'b1);
        n_tests++; if (vld4 !== 1'b1) begin n_fail++; $display("FAIL accw_valid: got %b expected 1", vld4); end
        n_tests++; if (cnt4 !== exp_cnt4) begin n_fail++; $display("FAIL accw_count: got %0d expected %0d", cnt4, exp_cnt4); end
        n_tests++; if (ovf4 !== 1'b1) begin n_fail++; $display("FAIL accw_ovf: got %b expected 1", ovf4); end
        n_tests++; if (bts4 !== 8'd3) begin n_fail++; $display("FAIL accw_beats: got %0d expected 3", bts4); end
        n_tests++; if (cnt0 !== 16'd21 || ovf0 !== 1'b0) begin n_fail++; $display("FAIL accw_wide_ref: got count=%0d ovf=%b expected 21 0", cnt0, ovf0); end
        release_result();
    endtask

    task automatic test_beat_overflow();
        logic [1:0] exp_bts2;
`ifdef BINCNT_ACCUM_SAT_EN
        exp_bts2 = 2'd3;
`else
        exp_bts2 = 2'd1;
`endif
        for (int i = 0; i < 4; i++) drive_beat(7'h01, 1'b0);
        drive_beat(7'h01, 1'b1);
        n_tests++; if (vld2 !== 1'b1) begin n_fail++; $display("FAIL beatw_valid: got %b expected 1", vld2); end
        n_tests++; if (bts2 !== exp_bts2) begin n_fail++; $display("FAIL beatw_beats: got %0d expected %0d", bts2, exp_bts2); end
        n_tests++; if (cnt2 !== 16'd5) begin n_fail++; $display("FAIL beatw_count: got %0d expected 5", cnt2); end
        n_tests++; if (ovf2 !== 1'b1) begin n_fail++; $display("FAIL beatw_ovf: got %b expected 1", ovf2); end
        n_tests++; if (bts0 !== 8'd5 || ovf0 !== 1'b0) begin n_fail++; $display("FAIL beatw_wide_ref: got beats=%0d ovf=%b expected 5 0", bts0, ovf0); end
        release_result();
    endtask

    task automatic test_clr();
        drive_beat(7'h0F, 1'b0);
        drive_beat(7'h0F, 1'b0);
        clr = 1'b1;
        drive_beat(7'h7F, 1'b0);
        clr = 1'b0;
        n_tests++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL clr_ready: got %b expected 1", rdy0); end
        drive_beat(7'h03, 1'b1);
        n_tests++; if (cnt0 !== 16'd2 || bts0 !== 8'd1 || ovf0 !== 1'b0)
        begin n_fail++; $display("FAIL clr_frame: got count=%0d beats=%0d ovf=%b expected 2 1 0", cnt0, bts0, ovf0); end
        // A pending result is dropped by clr in HOLD.
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        n_tests++; if ({vld0, rdy0} !== 2'b01) begin n_fail++; $display("FAIL clr_in_hold: got valid,ready=%b expected 01", {vld0, rdy0}); end
    endtask

    task automatic test_async_reset();
        drive_beat(7'h7F, 1'b0);
        drive_beat(7'h01, 1'b1);
        n_tests++; if (vld0 !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid: got %b expected 1", vld0); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (vld0 !== 1'b0) begin n_fail++; $display("FAIL areset_valid_drop: got %b expected 0", vld0); end
        n_tests++; if (rdy0 !== 1'b0 || cnt0 !== 16'd0) begin n_fail++; $display("FAIL areset_state: got ready=%b count=%0d expected 0 0", rdy0, cnt0); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got %b expected 1", rdy0); end
        drive_beat(7'h55, 1'b0);
        drive_beat(7'h03, 1'b1);
        n_tests++; if (cnt0 !== 16'd6 || bts0 !== 8'd2 || vld0 !== 1'b1)
        begin n_fail++; $display("FAIL areset_next_frame: got count=%0d beats=%0d valid=%b expected 6 2 1", cnt0, bts0, vld0); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_hold_backpressure();
        test_acc_overflow();
        test_beat_overflow();
        test_clr();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
